// File: rtl/fetch_pc_unit.sv
// Program counter register and instruction fetch stage.
// Optional macro FETCH_PERF_CNT_EN adds retired-instruction and stall counters.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        halt,
  output logic [31:0] program_counter,
  input  logic [31:0] program_counter_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_instr_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

  localparam logic [1:0] CODE_MISALIGNED = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT    = 2'd2;
  // Fault fires at the edge that ends the IMEM_TIMEOUT-th unacknowledged cycle.
  localparam logic [7:0] TIMEOUT_LAST    = 8'(IMEM_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] instr_pc_reg, instr_pc_next;
  logic        instr_valid_reg, instr_valid_next;
  logic        imem_req_reg, imem_req_next;
  logic        fault_reg, fault_next;
  logic [1:0]  fault_code_reg, fault_code_next;
  logic [7:0]  cnt_reg, cnt_next;

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;
    instr_valid_next = instr_valid_reg;
    imem_req_next    = imem_req_reg;
    fault_next       = fault_reg;
    fault_code_next  = fault_code_reg;
    cnt_next         = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (!halt && !fault_reg) begin
          state_next    = FETCH;
          imem_req_next = 1'b1;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          instr_next       = imem_rdata;
          instr_pc_next    = pc_reg;
          instr_valid_next = 1'b1;
          cnt_next         = 8'd0;
          imem_req_next    = 1'b0;
          state_next       = HOLD;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          cnt_next        = cnt_reg + 8'd1;
          fault_next      = 1'b1;
          fault_code_next = CODE_TIMEOUT;
          imem_req_next   = 1'b0;
          state_next      = FAULT;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      HOLD: begin
        // The request for the next fetch is registered, so instr_ready never
        // reaches imem_req combinationally.
        if (instr_ready) begin
          instr_valid_next = 1'b0;
          if (program_counter_next[1:0] == 2'b00) begin
            pc_next       = program_counter_next;
            state_next    = halt ? IDLE : FETCH;
            imem_req_next = !halt;
          end else begin
            fault_next      = 1'b1;
            fault_code_next = CODE_MISALIGNED;
            state_next      = FAULT;
          end
        end
      end
      default: begin
        imem_req_next    = 1'b0;
        instr_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      instr_reg       <= 32'd0;
      instr_pc_reg    <= 32'd0;
      instr_valid_reg <= 1'b0;
      imem_req_reg    <= 1'b0;
      fault_reg       <= 1'b0;
      fault_code_reg  <= 2'd0;
      cnt_reg         <= 8'd0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
      instr_valid_reg <= instr_valid_next;
      imem_req_reg    <= imem_req_next;
      fault_reg       <= fault_next;
      fault_code_reg  <= fault_code_next;
      cnt_reg         <= cnt_next;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_instr_cnt_reg, perf_stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_instr_cnt_reg <= 32'd0;
      perf_stall_cnt_reg <= 32'd0;
    end else begin
      if (state_reg == HOLD && instr_ready && program_counter_next[1:0] == 2'b00)
        perf_instr_cnt_reg <= perf_instr_cnt_reg + 32'd1;
      if ((state_reg == FETCH && !imem_ack) || (state_reg == HOLD && !instr_ready))
        perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
    end
  end

  assign perf_instr_cnt = perf_instr_cnt_reg;
  assign perf_stall_cnt = perf_stall_cnt_reg;
`endif

  assign program_counter = pc_reg;
  assign imem_addr       = pc_reg;
  assign imem_req        = imem_req_reg;
  assign instr_valid     = instr_valid_reg;
  assign instr           = instr_reg;
  assign instr_pc        = instr_pc_reg;
  assign fault           = fault_reg;
  assign fault_code      = fault_code_reg;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit: fetch cadence, stalls,
// branch, misalignment, timeout, reset during fetch and halt.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        halt;
  logic [31:0] program_counter;
  logic [31:0] program_counter_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fault;
  logic [1:0]  fault_code;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_instr_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(16)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .halt                 (halt),
    .program_counter      (program_counter),
    .program_counter_next (program_counter_next),
    .imem_req             (imem_req),
    .imem_addr            (imem_addr),
    .imem_ack             (imem_ack),
    .imem_rdata           (imem_rdata),
    .instr_valid          (instr_valid),
    .instr_ready          (instr_ready),
    .instr                (instr),
    .instr_pc             (instr_pc),
`ifdef FETCH_PERF_CNT_EN
    .perf_instr_cnt       (perf_instr_cnt),
    .perf_stall_cnt       (perf_stall_cnt),
`endif
    .fault                (fault),
    .fault_code           (fault_code)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; halt = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0;
    instr_ready = 1'b0; program_counter_next = 32'd0;
    step(); step();
    checks++; if (program_counter !== 32'd0) begin errors++; $display("FAIL reset_pc actual=%0h required=0", program_counter); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req actual=%0b required=0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%0b required=0", instr_valid); end
    checks++; if (instr !== 32'd0 || instr_pc !== 32'd0) begin errors++; $display("FAIL reset_instr actual=%0h/%0h required=0/0", instr, instr_pc); end
    checks++; if (fault !== 1'b0 || fault_code !== 2'd0) begin errors++; $display("FAIL reset_fault actual=%0b/%0d required=0/0", fault, fault_code); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    reset_n = 1'b1; halt = 1'b0; imem_ack = 1'b1; instr_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(4 * i);
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL seq_fetch%0d actual=%0b/%0h required=1/%0h", i, imem_req, imem_addr, exp_pc); end
      imem_rdata = 32'hA000_0000 + 32'(i);
      program_counter_next = exp_pc + 32'd4;
      step();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== 32'hA000_0000 + 32'(i) || imem_req !== 1'b0) begin
        errors++; $display("FAIL seq_hold%0d actual=v%0b pc%0h i%0h r%0b required=v1 pc%0h i%0h r0", i, instr_valid, instr_pc, instr, imem_req, exp_pc, 32'hA000_0000 + 32'(i));
      end
      $display("seq instr pc=%0h instr=%0h", instr_pc, instr);
      step();
    end
  endtask

  task automatic test_stall();
    // Entered in FETCH at PC 0xC with ack still asserted.
    imem_rdata = 32'hEA00_0002; instr_ready = 1'b0; program_counter_next = 32'h100;
    step();
    imem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (instr_valid !== 1'b1 || instr !== 32'hEA00_0002 || instr_pc !== 32'hC || imem_req !== 1'b0 || program_counter !== 32'hC) begin
        errors++; $display("FAIL stall%0d actual=v%0b i%0h ipc%0h r%0b pc%0h required=v1 iea000002 ipcc r0 pcc", k, instr_valid, instr, instr_pc, imem_req, program_counter);
      end
      instr_ready = (k == 3);
      step();
    end
    checks++; if (program_counter !== 32'h100 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL stall_accept actual=pc%0h r%0b v%0b required=pc100 r1 v0", program_counter, imem_req, instr_valid); end
    $display("stall instr accepted, pc=%0h", program_counter);
  endtask

  task automatic test_branch();
    imem_ack = 1'b1; imem_rdata = 32'h1111_0000; instr_ready = 1'b1; program_counter_next = 32'h110;
    step();
    checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL branch_src actual=%0h required=100", instr_pc); end
    step();
    checks++; if (imem_addr !== 32'h110 || imem_req !== 1'b1) begin errors++; $display("FAIL branch_addr actual=%0h/%0b required=110/1", imem_addr, imem_req); end
    instr_ready = 1'b0;
    step();
    checks++; if (instr_pc !== 32'h110 || instr_valid !== 1'b1) begin errors++; $display("FAIL branch_ipc actual=%0h/%0b required=110/1", instr_pc, instr_valid); end
    $display("branch to pc=%0h", instr_pc);
  endtask

  task automatic test_misaligned();
    // In HOLD at PC 0x110.
    imem_ack = 1'b0; instr_ready = 1'b1; program_counter_next = 32'h102;
    step();
    checks++; if (fault !== 1'b1 || fault_code !== 2'd1) begin errors++; $display("FAIL misalign_fault actual=%0b/%0d required=1/1", fault, fault_code); end
    checks++; if (program_counter !== 32'h110 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL misalign_state actual=pc%0h v%0b r%0b required=pc110 v0 r0", program_counter, instr_valid, imem_req); end
    imem_ack = 1'b1; program_counter_next = 32'h200;
    step(); step(); step();
    checks++; if (fault !== 1'b1 || fault_code !== 2'd1 || imem_req !== 1'b0 || program_counter !== 32'h110) begin
      errors++; $display("FAIL misalign_sticky actual=f%0b c%0d r%0b pc%0h required=f1 c1 r0 pc110", fault, fault_code, imem_req, program_counter);
    end
    $display("misaligned fault code=%0d", fault_code);
  endtask

  task automatic test_timeout();
    reset_n = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; halt = 1'b0;
    step();
    checks++; if (fault !== 1'b0 || program_counter !== 32'd0) begin errors++; $display("FAIL recover_reset actual=f%0b pc%0h required=f0 pc0", fault, program_counter); end
    reset_n = 1'b1;
    step();
    for (int c = 1; c < 16; c++) step();
    checks++; if (fault !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL timeout_early actual=f%0b r%0b required=f0 r1", fault, imem_req); end
    step();
    checks++; if (fault !== 1'b1 || fault_code !== 2'd2 || imem_req !== 1'b0) begin errors++; $display("FAIL timeout_fault actual=f%0b c%0d r%0b required=f1 c2 r0", fault, fault_code, imem_req); end
    $display("timeout fault code=%0d", fault_code);
  endtask

  task automatic test_reset_mid_fetch();
    reset_n = 1'b0; halt = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL midfetch_req actual=%0b required=1", imem_req); end
    reset_n = 1'b0; halt = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0 || program_counter !== 32'd0 || fault !== 1'b0) begin errors++; $display("FAIL midfetch_drop actual=r%0b pc%0h f%0b required=r0 pc0 f0", imem_req, program_counter, fault); end
    reset_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step(); step();
    checks++; if (instr_valid !== 1'b0 || instr !== 32'd0 || program_counter !== 32'd0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL late_ack actual=v%0b i%0h pc%0h r%0b required=v0 i0 pc0 r0", instr_valid, instr, program_counter, imem_req);
    end
    imem_ack = 1'b0;
    $display("late ack ignored, pc=%0h", program_counter);
  endtask

  task automatic test_halt();
    // IDLE with halt=1 at PC 0.
    halt = 1'b0;
    step();
    halt = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("FAIL halt_keepfetch actual=%0b/%0h required=1/0", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h1234_5678) begin errors++; $display("FAIL halt_capture actual=%0b/%0h required=1/12345678", instr_valid, instr); end
    imem_ack = 1'b0; instr_ready = 1'b1; program_counter_next = 32'h40;
    step();
    instr_ready = 1'b0;
    step();
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || program_counter !== 32'h40) begin errors++; $display("FAIL halt_idle actual=r%0b v%0b pc%0h required=r0 v0 pc40", imem_req, instr_valid, program_counter); end
    halt = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL halt_resume actual=%0b/%0h required=1/40", imem_req, imem_addr); end
    imem_ack = 1'b1;
    step();
    checks++; if (instr_pc !== 32'h40) begin errors++; $display("FAIL halt_ipc actual=%0h required=40", instr_pc); end
    $display("halt resume pc=%0h", instr_pc);
  endtask

  task automatic test_wrap();
    // In HOLD at PC 0x40, ack asserted.
    instr_ready = 1'b1; program_counter_next = 32'hFFFF_FFFC;
    step();
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_hi actual=%0h required=fffffffc", imem_addr); end
    program_counter_next = 32'h0000_0000;
    step(); step();
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL wrap_lo actual=%0h/%0b/%0b required=0/1/0", imem_addr, imem_req, fault); end
    $display("wrap pc=%0h", imem_addr);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_misaligned();
    test_timeout();
    test_reset_mid_fetch();
    test_halt();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
